// File: rtl/conv_pkg.sv
// Shared convolution-engine definitions: default geometry, feature-map size
// helpers and the collector state type.
package conv_pkg;

  localparam int IM_DIM_DEF = 28;
  localparam int K_DIM_DEF  = 3;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } fmap_state_t;

  function automatic int out_dim(input int im_dim, input int k_dim);
    return im_dim - k_dim + 1;
  endfunction

  function automatic int n_pix(input int im_dim, input int k_dim);
    return (im_dim - k_dim + 1) * (im_dim - k_dim + 1);
  endfunction

endpackage

// File: rtl/fmap_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
module fmap_ram #(
  parameter int DEPTH = 676,
  parameter int WIDTH = 8,
  parameter int AW    = 10
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      r_mem[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_o <= r_mem[rd_addr_i];
    end
  end

endmodule

// File: rtl/fmap_collector.sv
// Captures one convolved feature map into a buffer, then streams it out in
// raster order over valid/ready through a 2-entry output skid.
module fmap_collector
  import conv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IM_DIM = IM_DIM_DEF,
  parameter int K_DIM  = K_DIM_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] pixel_i,
  input  logic              conv_valid_i,
  input  logic              image_done_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic              rd_last_o,
  output logic              collecting_o,
  output logic [$clog2(n_pix(IM_DIM, K_DIM)+1)-1:0] wr_count_o,
  output logic              overflow_o,
  output logic              short_o
);

  localparam int OUT_DIM = out_dim(IM_DIM, K_DIM);
  localparam int N_PIX   = OUT_DIM * OUT_DIM;
  localparam int CNT_W   = $clog2(N_PIX + 1);
  localparam logic [CNT_W-1:0] N_PIX_C  = CNT_W'(N_PIX);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_PIX - 1);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  fmap_state_t       r_state;
  logic [CNT_W-1:0]  r_wr_ptr, r_rd_ptr, r_len;
  logic              r_pend, r_pend_last;
  logic              r_out_vld, r_out_last, r_skid_vld, r_skid_last;
  logic [DATA_W-1:0] r_out_data, r_skid_data;
  logic              r_overflow, r_short;

  logic              w_wr_en, w_final_wr, w_pop, w_done, w_issue;
  logic [1:0]        w_occ;
  logic [CNT_W-1:0]  w_wr_next;
  logic [DATA_W-1:0] w_ram_data;

  assign w_wr_en    = (r_state == COLLECT) && conv_valid_i;
  assign w_final_wr = w_wr_en && (r_wr_ptr == LAST_IDX);
  assign w_wr_next  = r_wr_ptr + {{(CNT_W-1){1'b0}}, w_wr_en};
  assign w_pop      = r_out_vld && rd_ready_i;
  assign w_done     = w_pop && r_out_last;
  // Credits cover both skid entries plus the read already in flight.
  assign w_occ      = 2'(r_out_vld) + 2'(r_skid_vld) + 2'(r_pend);
  assign w_issue    = (r_state == DRAIN) && (r_rd_ptr < r_len) &&
                      ((w_occ - 2'(w_pop)) < 2'd2);

  fmap_ram #(.DEPTH(N_PIX), .WIDTH(DATA_W), .AW(CNT_W)) u_ram (
    .clk_i     (clk_i),
    .wr_en_i   (w_wr_en),
    .wr_addr_i (r_wr_ptr),
    .wr_data_i (pixel_i),
    .rd_en_i   (w_issue),
    .rd_addr_i (r_rd_ptr),
    .rd_data_o (w_ram_data)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pend      <= 1'b0;
      r_pend_last <= 1'b0;
      r_out_vld   <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_skid_vld  <= 1'b0;
      r_skid_last <= 1'b0;
      r_skid_data <= '0;
    end else begin
      r_pend      <= w_issue;
      r_pend_last <= w_issue && (r_rd_ptr == r_len - ONE_C);
      if (!r_out_vld || w_pop) begin
        if (r_skid_vld) begin
          r_out_vld   <= 1'b1;
          r_out_last  <= r_skid_last;
          r_out_data  <= r_skid_data;
          r_skid_vld  <= r_pend;
          r_skid_last <= r_pend_last;
          r_skid_data <= r_pend ? w_ram_data : r_skid_data;
        end else begin
          r_out_vld   <= r_pend;
          r_out_last  <= r_pend_last;
          r_out_data  <= r_pend ? w_ram_data : r_out_data;
          r_skid_vld  <= 1'b0;
          r_skid_last <= 1'b0;
        end
      end else if (r_pend) begin
        r_skid_vld  <= 1'b1;
        r_skid_last <= r_pend_last;
        r_skid_data <= w_ram_data;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= COLLECT;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_len      <= '0;
      r_overflow <= 1'b0;
      r_short    <= 1'b0;
    end else begin
      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + ONE_C;
      end
      case (r_state)
        COLLECT: begin
          r_wr_ptr <= w_wr_next;
          if (w_final_wr) begin
            r_state <= DRAIN;
            r_len   <= N_PIX_C;
          end else if (image_done_i) begin
            r_short <= 1'b1;
            if (w_wr_next != '0) begin
              r_state <= DRAIN;
              r_len   <= w_wr_next;
            end
          end
        end
        DRAIN: begin
          if (conv_valid_i) begin
            r_overflow <= 1'b1;
          end
          if (w_done) begin
            r_state  <= COLLECT;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
          end
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

  assign rd_data_o    = r_out_data;
  assign rd_valid_o   = r_out_vld;
  assign rd_last_o    = r_out_last;
  assign collecting_o = (r_state == COLLECT);
  assign wr_count_o   = r_wr_ptr;
  assign overflow_o   = r_overflow;
  assign short_o      = r_short;

endmodule
